// File: rtl/rob_pkg.sv
// Types and constants shared by the ROB and its commit stage.
package rob_pkg;

  localparam int                 ROB_W        = 32;
  localparam logic [ROB_W-1:0]   TRAP_VEC_DEF = 32'h0000_0100;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] dest_reg_id;
    logic [ROB_W-1:0] dest_reg_val;
    logic [ROB_W-1:0] pc;
    logic             control_bits;  // 1 = store
    logic [ROB_W-1:0] store_addr;
    logic [ROB_W-1:0] store_data;
    logic             exception;
  } entry_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } commit_state_t;

endpackage

// File: rtl/rob_store_slot.sv
// Single-entry store request holder: load, hold until the port accepts, clear on handshake.
module rob_store_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_addr,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] addr,
  output logic [W-1:0] data,
  output logic         fire
);

  assign fire = valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rob_commit.sv
// In-order commit stage for the ROB head: register writeback, store drain, exception flush.
// Define ROB_COMMIT_PERF_EN to build the retired-instruction counter.
module rob_commit
  import rob_pkg::*;
#(
  parameter int                  BITWIDTH = 32,
  parameter logic [BITWIDTH-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                head_valid,
  input  logic [BITWIDTH-1:0] head_dest_id,
  input  logic [BITWIDTH-1:0] head_dest_val,
  input  logic [BITWIDTH-1:0] head_pc,
  input  logic                head_ctrl,
  input  logic [BITWIDTH-1:0] head_store_addr,
  input  logic [BITWIDTH-1:0] head_store_data,
  input  logic                head_exception,
  output logic                head_pop,
  output logic                rf_we,
  output logic [BITWIDTH-1:0] rf_waddr,
  output logic [BITWIDTH-1:0] rf_wdata,
  output logic                st_req_valid,
  input  logic                st_req_ready,
  output logic [BITWIDTH-1:0] st_addr,
  output logic [BITWIDTH-1:0] st_data,
  output logic                flush,
  output logic [BITWIDTH-1:0] redirect_pc,
  output logic [BITWIDTH-1:0] epc,
  output logic [31:0]         retired_count
);

  commit_state_t state, state_nxt;
  logic          in_run, reg_commit, st_load, exc_take, st_fire;

  // Register commits are combinational off the head, so reset must mask them explicitly.
  assign in_run     = rst_n && (state == RUN) && head_valid;
  assign exc_take   = in_run && head_exception;
  assign reg_commit = in_run && !head_exception && !head_ctrl;
  assign st_load    = in_run && !head_exception && head_ctrl;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (exc_take)     state_nxt = FLUSH;
        else if (st_load) state_nxt = STORE_WAIT;
      end
      STORE_WAIT: if (st_fire) state_nxt = RUN;
      FLUSH:      state_nxt = RUN;
      default:    state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      epc   <= '0;
    end else begin
      state <= state_nxt;
      if (exc_take) epc <= head_pc;
    end
  end

  rob_store_slot #(.W(BITWIDTH)) u_store_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (st_load),
    .load_addr (head_store_addr),
    .load_data (head_store_data),
    .ready     (st_req_ready),
    .valid     (st_req_valid),
    .addr      (st_addr),
    .data      (st_data),
    .fire      (st_fire)
  );

  assign head_pop    = reg_commit | st_fire;
  assign rf_we       = reg_commit && (head_dest_id != '0);
  assign rf_waddr    = reg_commit ? head_dest_id  : '0;
  assign rf_wdata    = reg_commit ? head_dest_val : '0;
  assign flush       = (state == FLUSH);
  assign redirect_pc = flush ? TRAP_VEC : '0;

`ifdef ROB_COMMIT_PERF_EN
  logic [31:0] count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_q <= '0;
    else if (head_pop) count_q <= count_q + 32'd1;
  end
  assign retired_count = count_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: per-scenario tasks plus a scoreboard monitor checking every head pop.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        head_valid, head_ctrl, head_exception, st_req_ready;
  logic [31:0] head_dest_id, head_dest_val, head_pc, head_store_addr, head_store_data;
  logic        head_pop, rf_we, st_req_valid, flush;
  logic [31:0] rf_waddr, rf_wdata, st_addr, st_data, redirect_pc, epc, retired_count;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;

  typedef struct {
    bit          st;
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rob_commit dut (
    .clk(clk), .rst_n(rst_n),
    .head_valid(head_valid), .head_dest_id(head_dest_id), .head_dest_val(head_dest_val),
    .head_pc(head_pc), .head_ctrl(head_ctrl), .head_store_addr(head_store_addr),
    .head_store_data(head_store_data), .head_exception(head_exception),
    .head_pop(head_pop), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_addr(st_addr), .st_data(st_data), .flush(flush), .redirect_pc(redirect_pc),
    .epc(epc), .retired_count(retired_count)
  );

  // Scoreboard: every pop must match the oldest expected retire.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) pops = 0;
    else if (head_pop === 1'b1) begin
      n_tests++;
      pops++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_pop: head_pop=1 with no retire expected");
      end else begin
        e = sb.pop_front();
        if (e.st) begin
          if (st_req_valid !== 1'b1 || st_addr !== e.a || st_data !== e.d || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_store_pop: valid=%b addr=%h data=%h we=%b, want 1 %h %h 0",
                     st_req_valid, st_addr, st_data, rf_we, e.a, e.d);
          end
        end else if (rf_we !== e.we || (e.we && (rf_waddr !== e.a || rf_wdata !== e.d))) begin
          n_fail++;
          $display("FAIL sb_reg_pop: we=%b waddr=%h wdata=%h, want %b %h %h",
                   rf_we, rf_waddr, rf_wdata, e.we, e.a, e.d);
        end
      end
    end
  end

  task automatic set_head(input bit v, exc, ctrl, input logic [31:0] dest, val, pc, addr, data);
    head_valid = v; head_exception = exc; head_ctrl = ctrl;
    head_dest_id = dest; head_dest_val = val; head_pc = pc;
    head_store_addr = addr; head_store_data = data;
  endtask

  task automatic push_reg(input logic [31:0] dest, val);
    sb.push_back('{st: 1'b0, we: (dest != 0), a: dest, d: val});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st_req_ready = 1'b1;
    set_head(1, 0, 0, 32'd3, 32'hAA, 32'h40, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({head_pop, rf_we, st_req_valid, flush} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: pop/we/stv/flush=%b want 0000", {head_pop, rf_we, st_req_valid, flush});
    end
    n_tests++;
    if ({rf_waddr, rf_wdata, st_addr, st_data} !== 128'b0) begin
      n_fail++; $display("FAIL reset_data: waddr=%h wdata=%h saddr=%h sdata=%h want 0", rf_waddr, rf_wdata, st_addr, st_data);
    end
    n_tests++;
    if ({redirect_pc, epc, retired_count} !== 96'b0) begin
      n_fail++; $display("FAIL reset_misc: redir=%h epc=%h cnt=%h want 0", redirect_pc, epc, retired_count);
    end
    @(negedge clk);
    push_reg(32'd3, 32'hAA);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (head_pop !== 1'b1 || rf_waddr !== 32'd3) begin
      n_fail++; $display("FAIL reset_first_retire: pop=%b waddr=%h want 1 3", head_pop, rf_waddr);
    end
    @(negedge clk);
    head_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'hDEADBEEF; vals[1] = 32'd1; vals[2] = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_head(1, 0, 0, 32'(5 + i), vals[i], 32'h100 + 32'(4 * i), 32'h0, 32'h0);
      push_reg(32'(5 + i), vals[i]);
      #1;
      n_tests++;
      if (head_pop !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 32'(5 + i) || rf_wdata !== vals[i]) begin
        n_fail++; $display("FAIL b2b_%0d: pop=%b we=%b waddr=%h wdata=%h want 1 1 %h %h",
                           i, head_pop, rf_we, rf_waddr, rf_wdata, 32'(5 + i), vals[i]);
      end
    end
    @(negedge clk);
    head_valid = 1'b0;
    #1;
    n_tests++;
    if (head_pop !== 1'b0 || rf_we !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: pop=%b we=%b want 0 0", head_pop, rf_we);
    end
  endtask

  task automatic test_dest_zero();
    @(negedge clk);
    set_head(1, 0, 0, 32'd0, 32'h1234, 32'h200, 32'h0, 32'h0);
    push_reg(32'd0, 32'h1234);
    #1;
    n_tests++;
    if (head_pop !== 1'b1 || rf_we !== 1'b0) begin
      n_fail++; $display("FAIL dest_zero: pop=%b we=%b want 1 0", head_pop, rf_we);
    end
    @(negedge clk);
    head_valid = 1'b0;
  endtask

  task automatic test_store();
    @(negedge clk);
    st_req_ready = 1'b0;
    set_head(1, 0, 1, 32'd9, 32'h0, 32'h300, 32'h1000, 32'h55);
    sb.push_back('{st: 1'b1, we: 1'b0, a: 32'h1000, d: 32'h55});
    #1;
    n_tests++;
    if (head_pop !== 1'b0 || st_req_valid !== 1'b0 || rf_we !== 1'b0) begin
      n_fail++; $display("FAIL store_present: pop=%b stv=%b we=%b want 0 0 0", head_pop, st_req_valid, rf_we);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      head_store_addr = 32'hBAD0_0000 + 32'(k);
      head_store_data = 32'hBAD1_0000 + 32'(k);
      #1;
      n_tests++;
      if (st_req_valid !== 1'b1 || st_addr !== 32'h1000 || st_data !== 32'h55 || head_pop !== 1'b0) begin
        n_fail++; $display("FAIL store_wait_%0d: stv=%b addr=%h data=%h pop=%b want 1 1000 55 0",
                           k, st_req_valid, st_addr, st_data, head_pop);
      end
    end
    @(negedge clk);
    st_req_ready = 1'b1;
    #1;
    n_tests++;
    if (head_pop !== 1'b1 || st_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL store_handshake: pop=%b stv=%b want 1 1", head_pop, st_req_valid);
    end
    @(negedge clk);
    head_valid = 1'b0; st_req_ready = 1'b0;
    #1;
    n_tests++;
    if (st_req_valid !== 1'b0 || head_pop !== 1'b0) begin
      n_fail++; $display("FAIL store_done: stv=%b pop=%b want 0 0", st_req_valid, head_pop);
    end
  endtask

  task automatic test_exception();
    int cnt0;
    cnt0 = pops;
    @(negedge clk);
    set_head(1, 1, 1, 32'd4, 32'h0, 32'h2004, 32'h3000, 32'h77);
    #1;
    n_tests++;
    if (head_pop !== 1'b0 || st_req_valid !== 1'b0 || rf_we !== 1'b0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL exc_seen: pop=%b stv=%b we=%b flush=%b want 0 0 0 0", head_pop, st_req_valid, rf_we, flush);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (flush !== 1'b1 || redirect_pc !== 32'h100 || epc !== 32'h2004 || head_pop !== 1'b0) begin
      n_fail++; $display("FAIL exc_flush: flush=%b redir=%h epc=%h pop=%b want 1 100 2004 0", flush, redirect_pc, epc, head_pop);
    end
    @(negedge clk);
    head_valid = 1'b0;
    #1;
    n_tests++;
    if (flush !== 1'b0 || redirect_pc !== 32'h0 || epc !== 32'h2004 || st_req_valid !== 1'b0 || pops != cnt0) begin
      n_fail++; $display("FAIL exc_after: flush=%b redir=%h epc=%h stv=%b pops=%0d want 0 0 2004 0 %0d",
                         flush, redirect_pc, epc, st_req_valid, pops, cnt0);
    end
  endtask

  task automatic test_perf();
    int          base;
    logic [31:0] want;
    base = pops;
    st_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        set_head(1, 0, 1, 32'd0, 32'h0, 32'h500, 32'h4000, 32'hCAFE);
        sb.push_back('{st: 1'b1, we: 1'b0, a: 32'h4000, d: 32'hCAFE});
        @(negedge clk);
      end else begin
        set_head(1, 0, 0, 32'(i % 3), 32'h900 + 32'(i), 32'h500 + 32'(4 * i), 32'h0, 32'h0);
        push_reg(32'(i % 3), 32'h900 + 32'(i));
      end
    end
    @(negedge clk);
    set_head(1, 1, 0, 32'd1, 32'h0, 32'h600, 32'h0, 32'h0);
    @(negedge clk);
    head_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    n_tests++;
    if (pops - base != 10) begin
      n_fail++; $display("FAIL perf_pops: got %0d retires want 10", pops - base);
    end
`ifdef ROB_COMMIT_PERF_EN
    want = 32'(pops);
`else
    want = 32'd0;
`endif
    n_tests++;
    if (retired_count !== want) begin
      n_fail++; $display("FAIL perf_count: retired_count=%0d want %0d", retired_count, want);
    end
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk);
    st_req_ready = 1'b0;
    set_head(1, 0, 1, 32'd0, 32'h0, 32'h700, 32'h5000, 32'h99);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (st_req_valid !== 1'b0 || head_pop !== 1'b0 || retired_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_store: stv=%b pop=%b cnt=%0d want 0 0 0", st_req_valid, head_pop, retired_count);
    end
    @(negedge clk);
    head_valid = 1'b0;
    rst_n = 1'b1;
    st_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    n_tests++;
    if (st_req_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL final_drain: stv=%b pending=%0d want 0 0", st_req_valid, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_dest_zero();
    test_store();
    test_exception();
    test_perf();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
